// File: rtl/busca_pkg.sv
// busca_pkg: shared state encoding, opcode constants and default sizing for the fetch stage.
package busca_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
    localparam int ADDR_W_DEF = 5;
    localparam logic [7:0] HALT_OP_DEF = 8'h13;
    localparam logic [7:0] NOP_OP_DEF = 8'hFF;
endpackage

// File: rtl/memoria_programa.sv
// memoria_programa: program memory with synchronous write and registered read, no reset.
module memoria_programa #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage with valid/ready issue, HALT and end-of-program stop.
// Define UNIDADE_BUSCA_WRAP_EN to loop back to address 0 after the last instruction instead of halting.
module unidade_busca
    import busca_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [7:0] HALT_OP = HALT_OP_DEF,
    parameter logic [7:0] NOP_OP  = NOP_OP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              instr_ready,
    output logic [7:0]        instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);
`ifdef UNIDADE_BUSCA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   len_q, len_d;
    logic              valid_q, busy_q, halted_q;
    logic              idle_like, go, last;
    logic [7:0]        word;

    always_comb begin
        idle_like = state_q == IDLE || state_q == HALTED;
        go = idle_like && start && prog_len != '0;
        len_d = prog_len > DEPTH ? DEPTH : prog_len;
        last = {1'b0, pc_q} == len_q - (ADDR_W+1)'(1);
    end

    // The memory's read register doubles as the instruction register; it only reloads in FETCH.
    memoria_programa #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .we_i    (load_en && idle_like),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (state_q == FETCH),
        .raddr_i (pc_q),
        .rdata_o (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALTED: if (go) begin
                    state_q  <= FETCH;
                    pc_q     <= '0;
                    len_q    <= len_d;
                    busy_q   <= 1'b1;
                    halted_q <= 1'b0;
                end
                FETCH: begin
                    state_q <= ISSUE;
                    valid_q <= 1'b1;
                end
                ISSUE: if (instr_ready) begin
                    valid_q <= 1'b0;
                    if (word == HALT_OP || (last && !WRAP)) begin
                        state_q  <= HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                        pc_q    <= last ? '0 : pc_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr       = valid_q ? word : NOP_OP;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed and randomized checks of the fetch stage against a program-order model.
module tb_unidade_busca;
`ifdef UNIDADE_BUSCA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [7:0] HALT = 8'h13;

    logic       clk = 0, rst = 0, load_en = 0, start = 0, instr_ready = 0;
    logic [4:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic [5:0] prog_len = '0;
    logic [7:0] instr;
    logic       instr_valid, busy, halted;
    logic [4:0] pc;
    logic [7:0] mem_m [32];
    int checks = 0, errors = 0;

    unidade_busca dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start), .instr_ready(instr_ready), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse;
        rst = 1;
        step;
        rst = 0;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        load_en = 1;
        load_addr = 5'(a);
        load_data = d;
        step;
        load_en = 0;
        mem_m[a] = d;
    endtask

    task automatic do_start(input int pl, output int len);
        instr_ready = 0;
        prog_len = 6'(pl);
        start = 1;
        step;
        start = 0;
        len = pl > 32 ? 32 : pl;
        chk("start_busy", busy, pl != 0);
        chk("start_valid", instr_valid, 0);
        if (pl != 0) begin
            step;
            chk("first_valid", instr_valid, 1);
        end
    endtask

    // Walks the program in order; the model is just an index into mem_m plus the stop rules.
    task automatic issue_loop(input int len, input int max_x, input bit rnd);
        int idx = 0;
        int n = 0;
        logic [7:0] w;
        bit r;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            chk("valid", instr_valid, 1);
            chk("instr", instr, mem_m[idx]);
            chk("pc", pc, idx);
            w = mem_m[idx];
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            instr_ready = r;
            step;
            if (!r) continue;
            n++;
            if (w == HALT || (!WRAP && idx == len - 1)) begin
                chk("halt_flag", halted, 1);
                chk("halt_valid", instr_valid, 0);
                chk("halt_busy", busy, 0);
                chk("halt_pc", pc, idx);
                instr_ready = 0;
                return;
            end
            idx = idx == len - 1 ? 0 : idx + 1;
            chk("gap_valid", instr_valid, 0);
            chk("gap_busy", busy, 1);
            if (n >= max_x) begin
                instr_ready = 0;
                return;
            end
            step;
        end
        errors++;
        $display("FAIL issue_loop timeout observed no stop expected stop");
    endtask

    initial begin
        int len;
        logic [7:0] held;
        rst = 1;
        step;
        step;
        chk("rst_instr", instr, 8'hFF);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        rst = 0;

        load(0, 8'h00); load(1, 8'h01); load(2, 8'h13);
        do_start(3, len);
        issue_loop(len, 100, 0);

        load(0, 8'h05); load(1, 8'h06);
        do_start(2, len);
        issue_loop(len, 3, 0);
        if (!halted) rst_pulse;

        rst_pulse;
        do_start(0, len);
        chk("len0_halted", halted, 0);
        step;
        chk("len0_busy_later", busy, 0);

        do_start(2, len);
        load_en = 1; load_addr = 5'd1; load_data = 8'hAA;
        step;
        load_en = 0;
        chk("issue_load_hold", instr_valid, 1);
        issue_loop(len, 2, 0);
        if (!halted) rst_pulse;

        do_start(2, len);
        held = instr;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bp_valid", instr_valid, 1);
            chk("bp_instr", instr, held);
            chk("bp_pc", pc, 0);
        end
        issue_loop(len, 2, 0);
        if (!halted) rst_pulse;

        load_en = 1; load_addr = 5'd0; load_data = 8'h77;
        prog_len = 6'd2; start = 1;
        step;
        load_en = 0; start = 0;
        mem_m[0] = 8'h77;
        step;
        chk("ld_start_valid", instr_valid, 1);
        issue_loop(2, 2, 0);
        if (!halted) rst_pulse;

        do_start(2, len);
        rst_pulse;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_instr", instr, 8'hFF);
        do_start(2, len);
        issue_loop(len, 2, 0);
        if (!halted) rst_pulse;

        for (int t = 0; t < 20; t++) begin
            int pl;
            pl = $urandom_range(1, 40);
            for (int a = 0; a < (pl > 32 ? 32 : pl); a++)
                load(a, $urandom_range(0, 7) == 0 ? HALT : 8'($urandom));
            do_start(pl, len);
            issue_loop(len, 3 * len, 1);
            if (!halted) rst_pulse;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
